// File: rtl/tsm_pkg.sv
// Shared constants, state encoding and error codes for the program loader.
package tsm_pkg;

    localparam int INSTRUCTION_LENGTH  = 13;
    localparam int INSTRUCTION_MEM     = 1000;
    localparam int PROG_COUNTER_LENGTH = 10;
    localparam int BIT_CNT_WIDTH       = $clog2(INSTRUCTION_LENGTH);

    localparam logic [PROG_COUNTER_LENGTH-1:0] WORD_LIMIT = PROG_COUNTER_LENGTH'(INSTRUCTION_MEM);
    localparam logic [PROG_COUNTER_LENGTH-1:0] WORD_ONE   = PROG_COUNTER_LENGTH'(1);
    localparam logic [BIT_CNT_WIDTH-1:0]       LAST_BIT   = BIT_CNT_WIDTH'(INSTRUCTION_LENGTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_FIRST = 3'd1,
        ST_SHIFT      = 3'd2,
        ST_RUN        = 3'd3,
        ST_ERR        = 3'd4
    } loader_state_t;

    typedef logic [1:0] err_code_t;

    localparam err_code_t ERR_NONE      = 2'b00;
    localparam err_code_t ERR_UNDERFLOW = 2'b01;
    localparam err_code_t ERR_OVERFLOW  = 2'b10;

    function automatic logic start_allowed(input loader_state_t s);
        return (s == ST_IDLE) || (s == ST_RUN) || (s == ST_ERR);
    endfunction

endpackage

// File: rtl/load_serializer.sv
// Holds one captured instruction word and walks bit_cnt across it, presenting
// one bit per cycle LSB first while advance is high.
module load_serializer
    import tsm_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          capture,
    input  logic                          advance,
    input  logic [INSTRUCTION_LENGTH-1:0] data,
    input  logic                          last_in,
    output logic                          word_done,
    output logic                          cpu_load_bit,
    output logic                          last
);

    logic [INSTRUCTION_LENGTH-1:0] shreg;
    logic [BIT_CNT_WIDTH-1:0]      bit_cnt;
    logic                          last_q;

    // A capture restarts the word even while the previous one is on its final bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg   <= '0;
            bit_cnt <= '0;
            last_q  <= 1'b0;
        end else if (capture) begin
            shreg   <= data;
            bit_cnt <= '0;
            last_q  <= last_in;
        end else if (advance && !word_done) begin
            bit_cnt <= bit_cnt + BIT_CNT_WIDTH'(1);
        end
    end

    assign word_done    = (bit_cnt == LAST_BIT);
    assign cpu_load_bit = advance ? shreg[bit_cnt] : 1'b0;
    assign last         = last_q;

endmodule

// File: rtl/program_loader.sv
// Load-and-run sequencer: streams instruction words into the core's serial load port.
// Optional feature: define LOADER_CHECKSUM_EN to accumulate an XOR checksum of accepted words.
module program_loader
    import tsm_pkg::*;
(
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           halt,
    input  logic                           word_valid,
    input  logic [INSTRUCTION_LENGTH-1:0]  word_data,
    input  logic                           word_last,
    output logic                           word_ready,
    output logic                           cpu_reset,
    output logic                           cpu_en,
    output logic                           cpu_load_bit,
    output logic                           busy,
    output logic                           running,
    output logic [1:0]                     err,
    output logic [PROG_COUNTER_LENGTH-1:0] word_count,
    output logic [INSTRUCTION_LENGTH-1:0]  checksum
);

    loader_state_t state;
    logic          shifting;
    logic          start_ok;
    logic          accept;
    logic          word_done;
    logic          last;

    assign shifting = (state == ST_SHIFT);
    assign start_ok = start && start_allowed(state);
    assign accept   = word_valid && word_ready;

    // A follow-on word is only taken on the final bit, so the core never sees a gap.
    always_comb begin
        word_ready = 1'b0;
        case (state)
            ST_WAIT_FIRST: word_ready = 1'b1;
            ST_SHIFT:      word_ready = word_done && !last && (word_count != WORD_LIMIT);
            default:       word_ready = 1'b0;
        endcase
    end

    load_serializer u_serializer (
        .clk          (clk),
        .reset        (reset),
        .capture      (accept),
        .advance      (shifting),
        .data         (word_data),
        .last_in      (word_last),
        .word_done    (word_done),
        .cpu_load_bit (cpu_load_bit),
        .last         (last)
    );

    // Outputs are registered together with the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cpu_reset  <= 1'b1;
            cpu_en     <= 1'b0;
            busy       <= 1'b0;
            running    <= 1'b0;
            err        <= ERR_NONE;
            word_count <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_ERR: begin
                    if (start_ok) begin
                        state      <= ST_WAIT_FIRST;
                        cpu_reset  <= 1'b1;
                        cpu_en     <= 1'b0;
                        busy       <= 1'b1;
                        running    <= 1'b0;
                        err        <= ERR_NONE;
                        word_count <= '0;
                    end
                end
                ST_WAIT_FIRST: begin
                    if (accept) begin
                        state      <= ST_SHIFT;
                        cpu_reset  <= 1'b0;
                        cpu_en     <= 1'b1;
                        word_count <= word_count + WORD_ONE;
                    end
                end
                ST_SHIFT: begin
                    if (word_done) begin
                        if (last) begin
                            state   <= ST_RUN;
                            cpu_en  <= 1'b0;
                            busy    <= 1'b0;
                            running <= 1'b1;
                        end else if (word_count == WORD_LIMIT) begin
                            state     <= ST_ERR;
                            err       <= ERR_OVERFLOW;
                            cpu_reset <= 1'b1;
                            cpu_en    <= 1'b0;
                            busy      <= 1'b0;
                        end else if (accept) begin
                            word_count <= word_count + WORD_ONE;
                        end else begin
                            // A stall would let the core run with a partial program.
                            state     <= ST_ERR;
                            err       <= ERR_UNDERFLOW;
                            cpu_reset <= 1'b1;
                            cpu_en    <= 1'b0;
                            busy      <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    if (start_ok) begin
                        state      <= ST_WAIT_FIRST;
                        cpu_reset  <= 1'b1;
                        cpu_en     <= 1'b0;
                        busy       <= 1'b1;
                        running    <= 1'b0;
                        err        <= ERR_NONE;
                        word_count <= '0;
                    end else if (halt) begin
                        state     <= ST_IDLE;
                        cpu_reset <= 1'b1;
                        running   <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cpu_reset <= 1'b1;
                    cpu_en    <= 1'b0;
                    busy      <= 1'b0;
                    running   <= 1'b0;
                end
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [INSTRUCTION_LENGTH-1:0] checksum_q;

    always_ff @(posedge clk) begin
        if (reset || start_ok) begin
            checksum_q <= '0;
        end else if (accept) begin
            checksum_q <= checksum_q ^ word_data;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a bit-serial core memory model.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        halt;
    logic        word_valid;
    logic [12:0] word_data;
    logic        word_last;
    logic        word_ready;
    logic        cpu_reset;
    logic        cpu_en;
    logic        cpu_load_bit;
    logic        busy;
    logic        running;
    logic [1:0]  err;
    logic [9:0]  word_count;
    logic [12:0] checksum;

    int total = 0;
    int bad   = 0;

    logic [12:0] wq [0:1023];
    logic [12:0] core_mem [0:3];
    int          core_ptr;

    always #5 clk = ~clk;

    program_loader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .halt         (halt),
        .word_valid   (word_valid),
        .word_data    (word_data),
        .word_last    (word_last),
        .word_ready   (word_ready),
        .cpu_reset    (cpu_reset),
        .cpu_en       (cpu_en),
        .cpu_load_bit (cpu_load_bit),
        .busy         (busy),
        .running      (running),
        .err          (err),
        .word_count   (word_count),
        .checksum     (checksum)
    );

    // Core load port: reset clears the load pointer, each enabled cycle writes one bit.
    always @(posedge clk) begin
        if (cpu_reset) begin
            core_ptr = 0;
            for (int i = 0; i < 4; i++) core_mem[i] = '0;
        end else if (cpu_en) begin
            if (core_ptr < 52) core_mem[core_ptr / 13][core_ptr % 13] = cpu_load_bit;
            core_ptr = core_ptr + 1;
        end
    end

    task automatic pulse(input logic s, input logic h);
        start = s;
        halt  = h;
        @(posedge clk);
        #1;
        start = 1'b0;
        halt  = 1'b0;
    endtask

    task automatic stream(input int n, input logic mark_last,
                          output int acc, output int en_cyc, output int lat);
        int   cyc;
        int   t0;
        logic hs;
        logic started;
        logic done;
        acc = 0; en_cyc = 0; lat = -1; cyc = 0; t0 = 0; started = 0; done = 0;
        word_valid = 1'b1;
        word_data  = wq[0];
        word_last  = mark_last && (n == 1);
        while (!done && cyc < 20000) begin
            @(negedge clk);
            if (started && !busy) begin
                done = 1;
                lat  = cyc - t0;
            end else begin
                if (cpu_en) en_cyc++;
                hs = word_valid && word_ready;
                @(posedge clk);
                #1;
                cyc++;
                if (hs) begin
                    if (!started) begin
                        started = 1;
                        t0 = cyc;
                    end
                    acc++;
                    if (acc < n) begin
                        word_data = wq[acc];
                        word_last = mark_last && (acc == n - 1);
                    end else begin
                        word_valid = 1'b0;
                        word_last  = 1'b0;
                    end
                end
            end
        end
        word_valid = 1'b0;
        word_last  = 1'b0;
        total++;
        if (!done) begin
            bad++;
            $display("[TB] FAIL stream_timeout: got no session end after %0d cycles, want end", cyc);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (cpu_reset !== 1'b1) begin bad++; $display("[TB] FAIL rst_cpu_reset: got %b want 1", cpu_reset); end
        total++; if (cpu_en !== 1'b0) begin bad++; $display("[TB] FAIL rst_cpu_en: got %b want 0", cpu_en); end
        total++; if (cpu_load_bit !== 1'b0) begin bad++; $display("[TB] FAIL rst_load_bit: got %b want 0", cpu_load_bit); end
        total++; if (word_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_ready: got %b want 0", word_ready); end
        total++; if (busy !== 1'b0 || running !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy_running: got %b%b want 00", busy, running); end
        total++; if (err !== 2'b00) begin bad++; $display("[TB] FAIL rst_err: got %b want 00", err); end
        total++; if (word_count !== 10'd0) begin bad++; $display("[TB] FAIL rst_count: got %0d want 0", word_count); end
        total++; if (checksum !== 13'h0) begin bad++; $display("[TB] FAIL rst_checksum: got %h want 0", checksum); end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_two_words();
        int acc, en_cyc, lat;
        wq[0] = 13'h1A5;
        wq[1] = 13'h0F0;
        pulse(1'b1, 1'b0);
        total++; if (word_ready !== 1'b1 || cpu_reset !== 1'b1) begin bad++; $display("[TB] FAIL wait_first: got ready=%b rst=%b want 1 1", word_ready, cpu_reset); end
        stream(2, 1'b1, acc, en_cyc, lat);
        total++; if (acc !== 2) begin bad++; $display("[TB] FAIL two_accepted: got %0d want 2", acc); end
        total++; if (en_cyc !== 26) begin bad++; $display("[TB] FAIL two_en_cycles: got %0d want 26", en_cyc); end
        total++; if (lat !== 26) begin bad++; $display("[TB] FAIL two_run_latency: got %0d want 26", lat); end
        total++; if (core_mem[0] !== 13'h1A5) begin bad++; $display("[TB] FAIL two_mem0: got %h want 1a5", core_mem[0]); end
        total++; if (core_mem[1] !== 13'h0F0) begin bad++; $display("[TB] FAIL two_mem1: got %h want 0f0", core_mem[1]); end
        total++; if (running !== 1'b1 || cpu_en !== 1'b0 || cpu_reset !== 1'b0) begin bad++; $display("[TB] FAIL two_run_state: got run=%b en=%b rst=%b want 1 0 0", running, cpu_en, cpu_reset); end
        total++; if (word_count !== 10'd2) begin bad++; $display("[TB] FAIL two_count: got %0d want 2", word_count); end
        total++; if (err !== 2'b00) begin bad++; $display("[TB] FAIL two_err: got %b want 00", err); end
    endtask

    task automatic test_halt_start();
        int acc, en_cyc, lat;
        pulse(1'b0, 1'b1);
        @(negedge clk);
        total++; if (running !== 1'b0 || cpu_reset !== 1'b1) begin bad++; $display("[TB] FAIL halt_idle: got run=%b rst=%b want 0 1", running, cpu_reset); end
        total++; if (busy !== 1'b0 || word_ready !== 1'b0) begin bad++; $display("[TB] FAIL halt_idle_busy: got busy=%b ready=%b want 0 0", busy, word_ready); end
        @(posedge clk);
        #1;
        pulse(1'b1, 1'b0);
        stream(2, 1'b1, acc, en_cyc, lat);
        pulse(1'b1, 1'b1);
        @(negedge clk);
        total++; if (busy !== 1'b1 || word_ready !== 1'b1 || running !== 1'b0) begin bad++; $display("[TB] FAIL start_halt_wait: got busy=%b ready=%b run=%b want 1 1 0", busy, word_ready, running); end
        total++; if (word_count !== 10'd0 || cpu_reset !== 1'b1) begin bad++; $display("[TB] FAIL start_halt_clear: got cnt=%0d rst=%b want 0 1", word_count, cpu_reset); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_underflow();
        int acc, en_cyc, lat;
        wq[0] = 13'h0AAA;
        pulse(1'b1, 1'b0);
        stream(1, 1'b0, acc, en_cyc, lat);
        total++; if (err !== 2'b01) begin bad++; $display("[TB] FAIL under_err: got %b want 01", err); end
        total++; if (cpu_reset !== 1'b1 || cpu_en !== 1'b0) begin bad++; $display("[TB] FAIL under_core: got rst=%b en=%b want 1 0", cpu_reset, cpu_en); end
        total++; if (word_count !== 10'd1) begin bad++; $display("[TB] FAIL under_count: got %0d want 1", word_count); end
        total++; if (lat !== 13) begin bad++; $display("[TB] FAIL under_latency: got %0d want 13", lat); end
        pulse(1'b0, 1'b1);
        @(negedge clk);
        total++; if (err !== 2'b01 || cpu_reset !== 1'b1 || running !== 1'b0) begin bad++; $display("[TB] FAIL err_halt_ignored: got err=%b rst=%b run=%b want 01 1 0", err, cpu_reset, running); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_overflow();
        int acc, en_cyc, lat;
        for (int i = 0; i < 1001; i++) wq[i] = 13'(i * 7 + 3);
        pulse(1'b1, 1'b0);
        @(negedge clk);
        total++; if (err !== 2'b00 || busy !== 1'b1) begin bad++; $display("[TB] FAIL err_restart: got err=%b busy=%b want 00 1", err, busy); end
        @(posedge clk);
        #1;
        stream(1001, 1'b0, acc, en_cyc, lat);
        total++; if (acc !== 1000) begin bad++; $display("[TB] FAIL over_accepted: got %0d want 1000", acc); end
        total++; if (err !== 2'b10) begin bad++; $display("[TB] FAIL over_err: got %b want 10", err); end
        total++; if (word_count !== 10'd1000) begin bad++; $display("[TB] FAIL over_count: got %0d want 1000", word_count); end
        total++; if (lat !== 13000 || cpu_reset !== 1'b1) begin bad++; $display("[TB] FAIL over_end: got lat=%0d rst=%b want 13000 1", lat, cpu_reset); end
    endtask

    task automatic test_checksum();
        int          acc, en_cyc, lat;
        logic [12:0] want;
`ifdef LOADER_CHECKSUM_EN
        want = 13'h1FFE;
`else
        want = 13'h0000;
`endif
        wq[0] = 13'h1FFF;
        wq[1] = 13'h0001;
        pulse(1'b1, 1'b0);
        stream(2, 1'b1, acc, en_cyc, lat);
        total++; if (checksum !== want) begin bad++; $display("[TB] FAIL checksum_run: got %h want %h", checksum, want); end
        total++; if (running !== 1'b1) begin bad++; $display("[TB] FAIL checksum_running: got %b want 1", running); end
        pulse(1'b1, 1'b0);
        @(negedge clk);
        total++; if (checksum !== 13'h0) begin bad++; $display("[TB] FAIL checksum_clear: got %h want 0", checksum); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_shift();
        word_valid = 1'b1;
        word_data  = 13'h1234;
        word_last  = 1'b0;
        @(posedge clk);
        #1;
        word_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        total++; if (busy !== 1'b1 || cpu_en !== 1'b1) begin bad++; $display("[TB] FAIL mid_shift: got busy=%b en=%b want 1 1", busy, cpu_en); end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        total++; if (cpu_reset !== 1'b1 || cpu_en !== 1'b0) begin bad++; $display("[TB] FAIL mid_rst_core: got rst=%b en=%b want 1 0", cpu_reset, cpu_en); end
        total++; if (err !== 2'b00 || word_count !== 10'd0) begin bad++; $display("[TB] FAIL mid_rst_regs: got err=%b cnt=%0d want 00 0", err, word_count); end
        total++; if (busy !== 1'b0 || cpu_load_bit !== 1'b0 || word_ready !== 1'b0) begin bad++; $display("[TB] FAIL mid_rst_idle: got busy=%b bit=%b ready=%b want 0 0 0", busy, cpu_load_bit, word_ready); end
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        halt       = 1'b0;
        word_valid = 1'b0;
        word_data  = '0;
        word_last  = 1'b0;
        test_reset();
        test_two_words();
        test_halt_start();
        test_underflow();
        test_overflow();
        test_checksum();
        test_reset_mid_shift();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
